// File: rtl/dnn_top.sv
// dnn_top: a 4-4-2 fully connected network with 5-bit signed inputs and weights.
// The hidden layer applies ReLU; the output layer is linear at full precision.
// Each batch walks IDLE -> L1 -> WAIT1 -> WAIT2 -> L2 and ends with a one-cycle
// ready pulse on both outputs.
module dnn_top (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_ready,
  input  logic signed [4:0]  x0,
  input  logic signed [4:0]  x1,
  input  logic signed [4:0]  x2,
  input  logic signed [4:0]  x3,
  input  logic signed [4:0]  w04, w05, w06, w07,
  input  logic signed [4:0]  w14, w15, w16, w17,
  input  logic signed [4:0]  w24, w25, w26, w27,
  input  logic signed [4:0]  w34, w35, w36, w37,
  input  logic signed [4:0]  w48, w49, w58, w59,
  input  logic signed [4:0]  w68, w69, w78, w79,
  output logic signed [16:0] out0,
  output logic signed [16:0] out1,
  output logic               out0_ready,
  output logic               out1_ready
);

  typedef enum logic [2:0] {IDLE, L1, WAIT1, WAIT2, L2} state_t;

  state_t state, state_nxt;
  logic   cap_x, calc_h, calc_out;

  logic signed [4:0]  xr0, xr1, xr2, xr3;
  logic signed [11:0] h4, h5, h6, h7;

  // One hidden neuron: 4-term dot product, then ReLU. Operands are widened to
  // 12 bits so every product and the sum are exact at that width.
  function automatic logic signed [11:0] neuron(
    input logic signed [4:0] a0, a1, a2, a3,
    input logic signed [4:0] b0, b1, b2, b3
  );
    logic signed [11:0] s;
    s = {{7{a0[4]}}, a0} * {{7{b0[4]}}, b0}
      + {{7{a1[4]}}, a1} * {{7{b1[4]}}, b1}
      + {{7{a2[4]}}, a2} * {{7{b2[4]}}, b2}
      + {{7{a3[4]}}, a3} * {{7{b3[4]}}, b3};
    return s[11] ? 12'sd0 : s;
  endfunction

  // One output neuron: linear 4-term dot product at 17 bits, no clipping.
  function automatic logic signed [16:0] dot_out(
    input logic signed [11:0] a0, a1, a2, a3,
    input logic signed [4:0]  b0, b1, b2, b3
  );
    return {{5{a0[11]}}, a0} * {{12{b0[4]}}, b0}
         + {{5{a1[11]}}, a1} * {{12{b1[4]}}, b1}
         + {{5{a2[11]}}, a2} * {{12{b2[4]}}, b2}
         + {{5{a3[11]}}, a3} * {{12{b3[4]}}, b3};
  endfunction

  // State register; reset wins over any transition.
  // NOTE: sequential state uses non-blocking (<=) so all registers update from
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-state strobes selecting what the datapath samples.
  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    cap_x     = 1'b0;
    calc_h    = 1'b0;
    calc_out  = 1'b0;
    case (state)
      IDLE: begin
        if (in_ready) begin
          cap_x     = 1'b1;
          state_nxt = L1;
        end
      end
      L1: begin
        calc_h    = 1'b1;
        state_nxt = WAIT1;
      end
      WAIT1: state_nxt = WAIT2;
      WAIT2: state_nxt = L2;
      L2: begin
        calc_out  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture x, compute hidden layer, compute outputs, pulse ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      xr0 <= '0; xr1 <= '0; xr2 <= '0; xr3 <= '0;
      h4  <= '0; h5  <= '0; h6  <= '0; h7  <= '0;
      out0       <= '0;
      out1       <= '0;
      out0_ready <= 1'b0;
      out1_ready <= 1'b0;
    end else begin
      out0_ready <= calc_out;
      out1_ready <= calc_out;
      if (cap_x) begin
        xr0 <= x0; xr1 <= x1; xr2 <= x2; xr3 <= x3;
      end
      if (calc_h) begin
        h4 <= neuron(xr0, xr1, xr2, xr3, w04, w14, w24, w34);
        h5 <= neuron(xr0, xr1, xr2, xr3, w05, w15, w25, w35);
        h6 <= neuron(xr0, xr1, xr2, xr3, w06, w16, w26, w36);
        h7 <= neuron(xr0, xr1, xr2, xr3, w07, w17, w27, w37);
      end
      if (calc_out) begin
        out0 <= dot_out(h4, h5, h6, h7, w48, w58, w68, w78);
        out1 <= dot_out(h4, h5, h6, h7, w49, w59, w69, w79);
      end
    end
  end

endmodule

// File: tb/tb_dnn_top.sv
// Directed testbench for dnn_top. Expected outputs come from an integer model
// and are queued with the cycle on which the ready pulse is due; every cycle
// checks the ready pulses and that outputs hold between results.
module tb_dnn_top;

  logic clk = 1'b0;
  logic rst;
  logic in_ready;
  logic signed [4:0] x  [4];
  logic signed [4:0] w1 [4][4];   // w1[i][j-4] = wij
  logic signed [4:0] w2 [4][2];   // w2[j-4][k-8] = wjk
  logic signed [16:0] out0, out1;
  logic out0_ready, out1_ready;

  typedef struct {
    int                 due;
    logic signed [16:0] o0;
    logic signed [16:0] o1;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  logic signed [16:0] last0, last1;

  always #5 clk = ~clk;

  dnn_top dut (
    .clk(clk), .rst(rst), .in_ready(in_ready),
    .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]),
    .w04(w1[0][0]), .w05(w1[0][1]), .w06(w1[0][2]), .w07(w1[0][3]),
    .w14(w1[1][0]), .w15(w1[1][1]), .w16(w1[1][2]), .w17(w1[1][3]),
    .w24(w1[2][0]), .w25(w1[2][1]), .w26(w1[2][2]), .w27(w1[2][3]),
    .w34(w1[3][0]), .w35(w1[3][1]), .w36(w1[3][2]), .w37(w1[3][3]),
    .w48(w2[0][0]), .w49(w2[0][1]), .w58(w2[1][0]), .w59(w2[1][1]),
    .w68(w2[2][0]), .w69(w2[2][1]), .w78(w2[3][0]), .w79(w2[3][1]),
    .out0(out0), .out1(out1), .out0_ready(out0_ready), .out1_ready(out1_ready)
  );

  task automatic check(input string tag, input logic signed [16:0] obs,
                       input logic signed [16:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, expv);
    end
  endtask

  // Integer reference of the network using the bench's current port values.
  function automatic logic signed [16:0] model(input int k);
    int h, acc;
    acc = 0;
    for (int j = 0; j < 4; j++) begin
      h = 0;
      for (int i = 0; i < 4; i++) h += int'(x[i]) * int'(w1[i][j]);
      if (h < 0) h = 0;
      acc += h * int'(w2[j][k]);
    end
    return acc[16:0];
  endfunction

  // Queue a result expected on the 5th edge from now (capture is the next edge).
  task automatic push();
    exp_t e;
    e.due = cyc + 5;
    e.o0  = model(0);
    e.o1  = model(1);
    exp_q.push_back(e);
  endtask

  // Advance one edge, then check ready pulses and output values.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check("ready0_pulse", 17'(out0_ready), 17'sd1);
      check("ready1_pulse", 17'(out1_ready), 17'sd1);
      check("out0_value", out0, e.o0);
      check("out1_value", out1, e.o1);
      last0 = e.o0;
      last1 = e.o1;
    end else begin
      check("ready0_idle", 17'(out0_ready), 17'sd0);
      check("ready1_idle", 17'(out1_ready), 17'sd0);
      check("out0_hold", out0, last0);
      check("out1_hold", out1, last1);
    end
  endtask

  task automatic set_all(input int xv, input int w1v, input int w2v0, input int w2v1);
    for (int i = 0; i < 4; i++) begin
      x[i] = 5'(xv);
      for (int j = 0; j < 4; j++) w1[i][j] = 5'(w1v);
      w2[i][0] = 5'(w2v0);
      w2[i][1] = 5'(w2v1);
    end
  endtask

  task automatic set_random();
    for (int i = 0; i < 4; i++) begin
      x[i] = 5'($urandom);
      for (int j = 0; j < 4; j++) w1[i][j] = 5'($urandom);
      w2[i][0] = 5'($urandom);
      w2[i][1] = 5'($urandom);
    end
  endtask

  // One isolated batch with inputs held steady, followed by two idle edges.
  task automatic batch();
    push();
    in_ready = 1'b1;
    step();
    in_ready = 1'b0;
    repeat (6) step();
  endtask

  logic signed [4:0] w2_keep [4][2];

  initial begin
    rst      = 1'b1;
    in_ready = 1'b0;
    last0    = '0;
    last1    = '0;
    set_all(0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
    step();

    // All ones: h = 4, outputs 16.
    set_all(1, 1, 1, 1);
    batch();

    // Negative hidden sums clipped to zero by ReLU.
    set_all(1, -1, 5, 5);
    batch();

    // Extremes: h = 1024, outputs -65536 and 61440.
    set_all(-16, -16, -16, 15);
    batch();

    // Random batches.
    repeat (3) begin
      set_random();
      batch();
    end

    // Back-to-back with in_ready held high; x scrambled outside IDLE.
    set_random();
    in_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 4; i++) x[i] = 5'($urandom);
      push();
      step();
      for (int i = 0; i < 4; i++) x[i] = 5'($urandom);
      repeat (4) step();
    end
    in_ready = 1'b0;
    repeat (2) step();

    // Reset during WAIT1 aborts the batch and clears the outputs.
    set_all(3, 2, 1, -1);
    push();
    in_ready = 1'b1;
    step();
    in_ready = 1'b0;
    step();
    rst = 1'b1;
    exp_q.delete();
    last0 = '0;
    last1 = '0;
    step();
    rst = 1'b0;
    repeat (6) step();

    // Fresh batch after reset computes correctly.
    set_random();
    batch();

    // Layer-2 weights wiggle during L1/WAIT1/WAIT2; only the L2-edge value counts.
    // Layer-1 weights change after the L1 edge and must not matter either.
    set_random();
    push();
    w2_keep  = w2;
    in_ready = 1'b1;
    step();
    in_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      w2[j][0] = ~w2_keep[j][0];
      w2[j][1] = ~w2_keep[j][1];
    end
    step();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) w1[i][j] = ~w1[i][j];
    for (int j = 0; j < 4; j++) begin
      w2[j][0] = 5'($urandom);
      w2[j][1] = 5'($urandom);
    end
    step();
    for (int j = 0; j < 4; j++) begin
      w2[j][0] = 5'sd15;
      w2[j][1] = -5'sd16;
    end
    step();
    w2 = w2_keep;
    step();
    for (int j = 0; j < 4; j++) begin
      w2[j][0] = 5'($urandom);
      w2[j][1] = 5'($urandom);
    end
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dnn_top.md
DNN_TOP -- requirements
Module: dnn_top

Interface
REQ-001 Parameters: none; all widths fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_ready  input  1  start request; sampled only in IDLE.
REQ-005 x0..x3  input  5 each, signed two's complement  network inputs.
REQ-006 w04..w07, w14..w17, w24..w27, w34..w37  input  5 each, signed  layer-1 weights; wij connects input i to hidden neuron j (4..7).
REQ-007 w48, w49, w58, w59, w68, w69, w78, w79  input  5 each, signed  layer-2 weights; wjk connects hidden neuron j to output k (8 -> out0, 9 -> out1).
REQ-008 out0, out1  output  17 each, signed  registered network outputs.
REQ-009 out0_ready, out1_ready  output  1 each  one-cycle result-valid pulses.

Function
REQ-010 The FSM SHALL have states IDLE, L1, WAIT1, WAIT2 and L2.
REQ-011 IDLE: if in_ready=1 at a clock edge, x0..x3 SHALL be registered and the state SHALL move to L1; otherwise the state SHALL stay IDLE.
REQ-012 L1: at the edge, layer-1 weights SHALL be sampled and h4..h7 registered, with hj = ReLU(x0*w0j + x1*w1j + x2*w2j + x3*w3j); next state WAIT1.
REQ-013 Hidden arithmetic: 5x5 signed products are 10 bits; sums are 12-bit signed (range -960..1024) with no overflow; ReLU maps negative values to 0.
REQ-014 WAIT1 SHALL go to WAIT2, and WAIT2 SHALL go to L2, with no other action.
REQ-015 L2: at the edge, layer-2 weights SHALL be sampled and out0 = h4*w48 + h5*w58 + h6*w68 + h7*w78 and out1 = h4*w49 + h5*w59 + h6*w69 + h7*w79 registered; next state IDLE.
REQ-016 Output arithmetic: full-precision signed; range -65536..61440 fits 17 bits exactly; no activation, saturation or truncation on outputs.
REQ-017 out0_ready and out1_ready SHALL both be 1 for exactly the one cycle following the L2 edge, and 0 otherwise.
REQ-018 Latency: result and ready SHALL appear 4 edges after the x-capture edge (capture at edge N, outputs valid and ready high after edge N+4).
REQ-019 in_ready SHALL be ignored in every state except IDLE; a new batch may be captured on the edge immediately after the L2 edge.
REQ-020 out0 and out1 SHALL hold their last values until the next L2 edge or reset.
REQ-021 Input ports SHALL be sampled only in the states stated above; changes at other times SHALL have no effect.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE and clear out0, out1, the ready outputs, captured x and h4..h7 to 0.
REQ-023 rst SHALL take priority over in_ready and over every state transition; a reset mid-batch SHALL abort the batch with no ready pulse.
REQ-024 After rst is deasserted, the first in_ready=1 edge SHALL start a fresh batch.

Verification
REQ-025 All x=1, all w1=1, all w2=1 -> h=4 each; out0=out1=16; ready pulses 4 edges after capture.
REQ-026 x=1, w1=-1, w2=5 -> every hidden sum is -4, so h=0 through ReLU; out0=out1=0.
REQ-027 x=-16, w1=-16 -> h=1024; w2 column 8 = -16 and column 9 = 15 -> out0=-65536, out1=61440.
REQ-028 Back-to-back: in_ready held high with new x each batch -> captures occur every 5 edges, one ready pulse per batch, each with correct values.
REQ-029 Assert rst during WAIT1 -> no ready pulse, outputs 0; the next batch computes correct values.
REQ-030 Change the w2 ports during L1, WAIT1 and WAIT2 -> only the value present at the L2 edge affects outputs.
